adder_seq64_arbiter: RTL
========================

Name: adder_seq64_arbiter

Overview:
- Sequences the OR1420 32-bit shared adder to perform 64-bit add, subtract and compare operations, two cycles per operation (low word, then high word).
- Arbitrates the adder between two requesters (e.g. custom-instruction unit and DMA address generator) using a req/done handshake with round-robin priority.
- Sits beside the adder; owns its opcode, carryIn, operand and flagMode inputs whenever it is busy.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = requester 0 always wins a tie.

Ports:
clock  input  1  system clock, all state on rising edge
resetN  input  1  synchronous reset, active low
req0, req1  input  1 each  operation request; held with operands stable until matching done
op0, op1  input  2 each  00 ADD64, 01 SUB64, 10 CMPU64, 11 CMPS64
opA0, opB0, opA1, opB1  input  64 each  operands
done0, done1  output  1 each  one-cycle completion pulse to the granted requester
result  output  64  sum/difference (compare ops: the difference)
carry  output  1  final adder carry (SUB/CMP: 1 = no borrow)
lt  output  1  64-bit less-than (unsigned for CMPU64, signed for CMPS64; 0 for ADD64/SUB64)
eq  output  1  64-bit A==B (compare ops only; else 0)
busy  output  1  high in every non-IDLE state
adderOpcode  output  2  drives adder opcode
adderCarryIn  output  1  drives adder carryIn
adderFlagMode  output  4  constant 4'b1111 (flag pass-through)
adderA, adderB  output  32 each  adder operands
adderSum  input  32  adder result
adderCarryOut  input  1  adder carryOut

Behaviour:
- Reset (resetN=0 at an edge): state IDLE; done0/1, busy, result, carry, lt, eq = 0; rr pointer = 0 (requester 0 preferred); adder outputs all 0. Reset mid-operation aborts it: no done is issued.
- Adder arithmetic: opcode 00 = A+B, carryIn ignored; 10 = A+B+carryIn; 11 = A+~B+1, carryIn ignored.
- FSM: IDLE -> LOW -> HIGH -> DONE -> IDLE.
- IDLE:
  - If any req, grant one. Both requesters: grant the one selected by the rr pointer (FIXED_PRIORITY=1: requester 0).
  - Latch op, opA and opB of the granted requester and the grant id; go LOW. Else stay.
- LOW:
  - Drive A[31:0] and B[31:0].
  - ADD: opcode 00. SUB/CMP: opcode 11.
  - Register the sum into result[31:0], adderCarryOut into cLow, and lowZero = (sum==0).
- HIGH:
  - Drive A[63:32]. ADD: B[63:32]. SUB/CMP: ~B[63:32] driven by this block.
  - Opcode 10 with carryIn = cLow.
  - Register result[63:32] and carry = adderCarryOut.
  - eq = lowZero & (high sum==0), compare ops only.
  - CMPU: lt = ~carryOut.
  - CMPS: V = (A63!=B63)&(R63!=A63), lt = R63^V.
- DONE:
  - Pulse done of the granted requester for exactly one cycle.
  - result/carry/lt/eq are valid from this cycle and held until the next DONE.
  - rr pointer := other requester; go IDLE.
- Latency: req sampled in IDLE at cycle 0 -> done at cycle 3. Throughput: one operation per 4 cycles.
- Requesters must deassert req on the edge ending the done cycle. A req still high in IDLE is treated as a new request.
- Operands are latched at grant, so requester changes after grant have no effect.
- Outside LOW/HIGH the adder outputs drive 0, with opcode 00 and flagMode 4'b1111.
- Only one done is ever high. done never asserts without a prior grant.

Test Plan:
- ADD64 on req0: A=0x00000000_FFFFFFFF, B=1 -> done0 at cycle 3, result=0x00000001_00000000, carry=0, lt=0, eq=0.
- SUB64 on req1: A=0, B=1 -> result=0xFFFFFFFF_FFFFFFFF, carry=0 (borrow). Check that during HIGH, adderB=0xFFFFFFFF, adderOpcode=10 and adderCarryIn=0.
- Compares with A=0xFFFFFFFF_FFFFFFFF, B=1:
  - CMPU64 -> lt=0, eq=0.
  - CMPS64 -> lt=1.
  - A=B=0x12345678_9ABCDEF0, CMPU64 -> eq=1, lt=0, carry=1.
- Arbitration: req0 and req1 held high continuously, FIXED_PRIORITY=0 -> grants alternate 0,1,0,1, with done pulses 4 cycles apart. With FIXED_PRIORITY=1 -> requester 0 is always served.
- Reset: resetN low during HIGH -> next cycle state IDLE, busy=0, no done pulse, outputs 0. A following req1 ADD64 (1+1) returns result=2.
- Hold check: change opA0 after grant -> result reflects the latched operands. req0 held one extra cycle after done0 -> a second operation starts.

Source files
------------

// File: rtl/adder_seq64_arbiter_if.sv
// Bundles the requester handshakes, the result flags and the shared 32-bit adder connection.
// The slave modport belongs to the sequencer; the master modport is the requesters, the adder and the bench.
interface adder_seq64_arbiter_if;
    logic        req0;
    logic        req1;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [63:0] opA0;
    logic [63:0] opB0;
    logic [63:0] opA1;
    logic [63:0] opB1;
    logic        done0;
    logic        done1;
    logic [63:0] result;
    logic        carry;
    logic        lt;
    logic        eq;
    logic        busy;
    logic [1:0]  adderOpcode;
    logic        adderCarryIn;
    logic [3:0]  adderFlagMode;
    logic [31:0] adderA;
    logic [31:0] adderB;
    logic [31:0] adderSum;
    logic        adderCarryOut;

    modport slave (
        input  req0, req1, op0, op1, opA0, opB0, opA1, opB1, adderSum, adderCarryOut,
        output done0, done1, result, carry, lt, eq, busy,
               adderOpcode, adderCarryIn, adderFlagMode, adderA, adderB
    );

    modport master (
        output req0, req1, op0, op1, opA0, opB0, opA1, opB1, adderSum, adderCarryOut,
        input  done0, done1, result, carry, lt, eq, busy,
               adderOpcode, adderCarryIn, adderFlagMode, adderA, adderB
    );
endinterface

// File: rtl/adder_seq64_arbiter.sv
// Runs 64-bit ADD/SUB/CMPU/CMPS on a shared 32-bit adder (low word, then high word) for two requesters.
// Grant to done is 3 cycles and one operation completes every 4 cycles; requesters hold req and operands until their done.
module adder_seq64_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clock,
    input  logic                  resetN,
    adder_seq64_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    // SUB64 is 2'b01; it shares the subtract path with the compares.
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMPU = 2'b10;
    localparam logic [1:0] OP_CMPS = 2'b11;

    state_t      r_state;
    logic        r_gnt;
    logic        r_rr;
    logic [1:0]  r_op;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [31:0] r_lo;
    logic        r_lowzero;
    logic        r_done0;
    logic        r_done1;
    logic        r_busy;
    logic [63:0] r_result;
    logic        r_carry;
    logic        r_lt;
    logic        r_eq;
    logic [1:0]  r_adder_op;
    logic        r_adder_ci;
    logic [31:0] r_adder_a;
    logic [31:0] r_adder_b;

    logic        w_gnt;
    logic [1:0]  w_sel_op;
    logic [63:0] w_sel_a;
    logic [63:0] w_sel_b;
    logic        w_is_add;
    logic        w_is_cmp;
    logic        w_sum_zero;
    logic        w_ovf;
    logic        w_lt;

    // A lone requester always wins; on a tie the pointer (or requester 0) decides.
    assign w_gnt    = (bus.req0 & bus.req1) ? (FIXED_PRIORITY ? 1'b0 : r_rr) : bus.req1;
    assign w_sel_op = w_gnt ? bus.op1  : bus.op0;
    assign w_sel_a  = w_gnt ? bus.opA1 : bus.opA0;
    assign w_sel_b  = w_gnt ? bus.opB1 : bus.opB0;

    assign w_is_add   = (r_op == OP_ADD);
    assign w_is_cmp   = r_op[1];
    assign w_sum_zero = (bus.adderSum == 32'd0);
    assign w_ovf      = (r_a[63] ^ r_b[63]) & (bus.adderSum[31] ^ r_a[63]);
    assign w_lt       = (r_op == OP_CMPU) ? ~bus.adderCarryOut :
                        (r_op == OP_CMPS) ? (bus.adderSum[31] ^ w_ovf) : 1'b0;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_gnt      <= 1'b0;
            r_rr       <= 1'b0;
            r_op       <= 2'b00;
            r_a        <= 64'd0;
            r_b        <= 64'd0;
            r_lo       <= 32'd0;
            r_lowzero  <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_busy     <= 1'b0;
            r_result   <= 64'd0;
            r_carry    <= 1'b0;
            r_lt       <= 1'b0;
            r_eq       <= 1'b0;
            r_adder_op <= 2'b00;
            r_adder_ci <= 1'b0;
            r_adder_a  <= 32'd0;
            r_adder_b  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        r_gnt      <= w_gnt;
                        r_op       <= w_sel_op;
                        r_a        <= w_sel_a;
                        r_b        <= w_sel_b;
                        r_busy     <= 1'b1;
                        r_adder_a  <= w_sel_a[31:0];
                        r_adder_b  <= w_sel_b[31:0];
                        r_adder_op <= (w_sel_op == OP_ADD) ? 2'b00 : 2'b11;
                        r_adder_ci <= 1'b0;
                        r_state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    // The low-word carry goes straight into the carryIn register for the high word.
                    r_lo       <= bus.adderSum;
                    r_lowzero  <= w_sum_zero;
                    r_adder_a  <= r_a[63:32];
                    r_adder_b  <= w_is_add ? r_b[63:32] : ~r_b[63:32];
                    r_adder_op <= 2'b10;
                    r_adder_ci <= bus.adderCarryOut;
                    r_state    <= S_HIGH;
                end
                S_HIGH: begin
                    r_result   <= {bus.adderSum, r_lo};
                    r_carry    <= bus.adderCarryOut;
                    r_eq       <= w_is_cmp & r_lowzero & w_sum_zero;
                    r_lt       <= w_lt;
                    r_done0    <= ~r_gnt;
                    r_done1    <= r_gnt;
                    r_adder_op <= 2'b00;
                    r_adder_ci <= 1'b0;
                    r_adder_a  <= 32'd0;
                    r_adder_b  <= 32'd0;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_rr    <= ~r_gnt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.done0         = r_done0;
    assign bus.done1         = r_done1;
    assign bus.result        = r_result;
    assign bus.carry         = r_carry;
    assign bus.lt            = r_lt;
    assign bus.eq            = r_eq;
    assign bus.busy          = r_busy;
    assign bus.adderOpcode   = r_adder_op;
    assign bus.adderCarryIn  = r_adder_ci;
    assign bus.adderFlagMode = 4'b1111;
    assign bus.adderA        = r_adder_a;
    assign bus.adderB        = r_adder_b;
endmodule
